// File: rtl/shift_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_engine_pkg
// Brief    : Mode encodings and FSM state type shared by the shift engine.
// Config   : SHIFT_ENGINE_ROTATE_EN enables the rotate-right mode.
// Revision : 1.0 - initial release
// ============================================================================
package shift_engine_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_engine_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_engine_step
// Brief    : Combinational one-bit shift of the working word by mode, giving
//            the next word and the bit that leaves it.
// Config   : SHIFT_ENGINE_ROTATE_EN adds the rotate-right path; without it
//            mode 11 falls through to the logical-right path.
// Revision : 1.0 - initial release
// ============================================================================
module shift_engine_step
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_data,
  output logic             out_bit
);

  // Select the one-bit shift; logical right is the fallback for unused modes.
  always_comb begin
    next_data = {1'b0, data[WIDTH-1:1]};
    out_bit   = data[0];
    case (mode)
      MODE_SLL: begin
        next_data = {data[WIDTH-2:0], 1'b0};
        out_bit   = data[WIDTH-1];
      end
      MODE_SRA: next_data = {data[WIDTH-1], data[WIDTH-1:1]};
`ifdef SHIFT_ENGINE_ROTATE_EN
      MODE_ROR: next_data = {data[0], data[WIDTH-1:1]};
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : shift_engine
// Brief    : Multi-cycle serial shifter (SLL/SRL/SRA/ROR), one bit per cycle,
//            with valid/ready handshakes on request and result.
// Config   : SHIFT_ENGINE_ROTATE_EN - when defined mode 11 rotates right,
//            otherwise mode 11 behaves as logical shift right.
// Revision : 1.0 - initial release
// ============================================================================
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             zero
);

  // Counter must be able to hold WIDTH itself (over-range shifts).
  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_count;
  logic [1:0]       r_mode;
  logic [CW-1:0]    w_eff;
  logic             w_accept;
  logic [31:0]      w_b32;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_bit;

  assign w_b32 = 32'(b);

  // Effective shift count: saturate at WIDTH, or wrap modulo WIDTH for rotate.
  always_comb begin
    w_eff = (w_b32 >= 32'(WIDTH)) ? CW'(WIDTH) : CW'(w_b32);
`ifdef SHIFT_ENGINE_ROTATE_EN
    if (mode == MODE_ROR) w_eff = CW'(w_b32 % 32'(WIDTH));
`endif
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_eff == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_count == CW'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  shift_engine_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data      (r_data),
    .mode      (r_mode),
    .next_data (w_step_data),
    .out_bit   (w_step_bit)
  );

  // Working word and count; result registers only load on entry to DONE so
  // they hold their previous values while idle or shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_count <= '0;
      r_mode  <= MODE_SLL;
      c       <= '0;
      carry   <= 1'b0;
      zero    <= 1'b1;
    end else if (w_accept) begin
      r_data  <= a;
      r_mode  <= mode;
      r_count <= w_eff;
      if (w_eff == '0) begin
        c     <= a;
        carry <= 1'b0;
        zero  <= (a == '0);
      end
    end else if (r_state == ST_SHIFT) begin
      r_data  <= w_step_data;
      r_count <= r_count - CW'(1);
      if (r_count == CW'(1)) begin
        c     <= w_step_data;
        carry <= w_step_bit;
        zero  <= (w_step_data == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_engine
// Brief    : Scoreboard bench for shift_engine (WIDTH = 20). Expected results
//            come from an arithmetic reference model or fixed vectors.
// Config   : honours SHIFT_ENGINE_ROTATE_EN for the mode-11 expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_engine;
  import shift_engine_pkg::*;

  localparam int W = 20;
  localparam int S = 5;

  typedef struct {
    logic [W-1:0] c;
    logic         carry;
    logic         zero;
    int           lat;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [S-1:0] b = '0;
  logic [1:0]   mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] c;
  logic         carry;
  logic         zero;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   bp_mode = 1'b0;
  exp_t sb[$];

  shift_engine #(.WIDTH(W), .SHW(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .carry     (carry),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain arithmetic on wide integers.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [S-1:0] tb, input logic [1:0] tm);
    exp_t        e;
    int          n;
    bit          rot;
    logic [63:0] x;
    longint      sx;
`ifdef SHIFT_ENGINE_ROTATE_EN
    rot = (tm == MODE_ROR);
`else
    rot = 1'b0;
`endif
    n = rot ? (int'(tb) % W) : ((int'(tb) > W) ? W : int'(tb));
    e.carry = 1'b0;
    if (tm == MODE_SLL) begin
      x = 64'(ta) << n;
      e.c = x[W-1:0];
      if (n > 0) e.carry = x[W];
    end else if (tm == MODE_SRA) begin
      sx = longint'({{(64-W){ta[W-1]}}, ta});
      x = 64'(sx >>> n);
      e.c = x[W-1:0];
      if (n > 0) e.carry = sx[n-1];
    end else if (rot) begin
      x = {24'b0, ta, ta} >> n;
      e.c = x[W-1:0];
      if (n > 0) e.carry = ta[n-1];
    end else begin
      e.c = ta >> n;
      if (n > 0) e.carry = ta[n-1];
    end
    e.zero = (e.c == '0);
    e.lat  = n + 1;
    e.acc  = 0;
    return e;
  endfunction

  // Issue one request; expectation is queued just before the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [S-1:0] tb, input logic [1:0] tm,
                      input bit push, input bit use_exp, input logic [W-1:0] ec,
                      input logic ecarry, input int elat);
    exp_t e;
    int   guard;
    @(negedge clk);
    a = ta; b = tb; mode = tm; in_valid = 1'b1;
    guard = 0;
    while (!in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 300) begin
        check("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    if (use_exp) begin
      e.c = ec; e.carry = ecarry; e.zero = (ec == '0); e.lat = elat;
    end else begin
      e = model(ta, tb, tm);
    end
    e.acc = cyc + 1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = S'($urandom); mode = 2'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (sb.size() != 0 || out_valid) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        check("drain_timeout", 32'(sb.size()), 32'd0);
        return;
      end
    end
  endtask

  // Monitor: pops one expectation per result and rechecks it every DONE cycle.
  initial begin : monitor
    exp_t cur;
    bit   have;
    bit   cur_ok;
    int   dcnt;
    have = 0; cur_ok = 0; dcnt = 0;
    cur.c = '0; cur.carry = 0; cur.zero = 0; cur.lat = 0; cur.acc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have = 0; dcnt = 0; out_ready = 1'b0;
      end else begin
        if (out_valid) begin
          check("in_ready_in_done", 32'(in_ready), 32'd0);
          if (!have) begin
            have = 1;
            if (sb.size() == 0) begin
              cur_ok = 0;
              checks++; errors++;
              $display("FAIL unexpected_result actual=out_valid required=no_result");
            end else begin
              cur = sb.pop_front();
              cur_ok = 1;
              check("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
            end
          end
          if (cur_ok) begin
            check("c", 32'(c), 32'(cur.c));
            check("carry", 32'(carry), 32'(cur.carry));
            check("zero", 32'(zero), 32'(cur.zero));
          end
          dcnt++;
        end else begin
          have = 0; dcnt = 0;
        end
        if (bp_mode && (!out_valid || dcnt < 5)) out_ready = 1'b0;
        else out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : main
    repeat (2) @(negedge clk);
    #1;
    check("rst_c", 32'(c), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Fixed vectors.
    send(20'h0000A, 5'd1, MODE_SRL, 1, 1, 20'h00005, 1'b0, 2);
    send(20'h0000A, 5'd3, MODE_SLL, 1, 1, 20'h00050, 1'b0, 4);
    send(20'h80000, 5'd4, MODE_SRA, 1, 1, 20'hF8000, 1'b0, 5);
`ifdef SHIFT_ENGINE_ROTATE_EN
    send(20'h00001, 5'd1, MODE_ROR, 1, 1, 20'h80000, 1'b1, 2);
    send(20'h00001, 5'd21, MODE_ROR, 1, 1, 20'h80000, 1'b1, 2);
`else
    send(20'h00001, 5'd1, MODE_ROR, 1, 1, 20'h00000, 1'b1, 2);
    send(20'h00001, 5'd21, MODE_ROR, 1, 1, 20'h00000, 1'b0, 21);
`endif
    send(20'hFFFFF, 5'd25, MODE_SLL, 1, 1, 20'h00000, 1'b1, 21);
    send(20'h12345, 5'd0, MODE_SRL, 1, 1, 20'h12345, 1'b0, 1);
    send(20'hF0F0F, 5'd31, MODE_SRA, 1, 1, 20'hFFFFF, 1'b1, 21);
    wait_idle();

    // Backpressure: results held for 5 DONE cycles, second request waits.
    bp_mode = 1'b1;
    send(20'h00F0F, 5'd2, MODE_SRL, 1, 0, '0, 1'b0, 0);
    send(20'h00003, 5'd1, MODE_SLL, 1, 0, '0, 1'b0, 0);
    wait_idle();
    bp_mode = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), S'($urandom), 2'($urandom), 1, 0, '0, 1'b0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    // Reset during SHIFT: no result may appear.
    send(20'h0ABCD, 5'd10, MODE_SLL, 0, 0, '0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_c", 32'(c), 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_in_ready_rel", 32'(in_ready), 32'd1);
    send(20'h00003, 5'd2, MODE_SLL, 1, 1, 20'h0000C, 1'b0, 3);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
